// File: rtl/tdm_mux8_tx_pkg.sv
// Shared types and sizing constants for the 8-slot TDM transmitter.
package tdm_mux8_tx_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SEL_W     = 3;
  // Hold counter width covers HOLD up to 16 (counts 0..15).
  localparam int HOLD_W    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_mux8_tx_slot_counter.sv
// Hold/slot counter: holds each select value for HOLD cycles, then advances.
module slot_counter
  import tdm_mux8_tx_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [SEL_W-1:0] o_sel,
  output logic             o_tc
);

  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD - 1);

  logic [HOLD_W-1:0] r_hold;
  logic [SEL_W-1:0]  r_sel;

  assign o_tc  = (r_hold == LAST_HOLD);
  assign o_sel = r_sel;

  // Select wraps 7 -> 0 naturally, which gives back-to-back frames for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_sel  <= '0;
    end else if (i_clear) begin
      r_hold <= '0;
      r_sel  <= '0;
    end else if (i_en) begin
      if (o_tc) begin
        r_hold <= '0;
        r_sel  <= r_sel + 1'b1;
      end else begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_mux8_tx.sv
// Serialises an 8-bit word onto a 1x8 demux: bit k is driven on D while S=k.
module tdm_mux8_tx
  import tdm_mux8_tx_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       din,
  output logic             D,
  output logic [SEL_W-1:0] S,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [7:0]       r_shadow;
  logic             w_send;
  logic             w_idle_start;
  logic             w_load;
  logic             w_tc;
  logic [SEL_W-1:0] w_sel;

  assign w_send       = (r_state == SEND);
  assign w_idle_start = !w_send && start;
  assign w_load       = w_idle_start || (done && start);

  slot_counter #(
    .HOLD(HOLD)
  ) u_slot_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clear(w_idle_start),
    .i_en   (w_send),
    .o_sel  (w_sel),
    .o_tc   (w_tc)
  );

  assign done  = w_send && w_tc && (w_sel == SEL_W'(NUM_SLOTS - 1));
  assign D     = w_send && r_shadow[w_sel];
  assign S     = w_sel;
  assign valid = w_send;
  assign busy  = w_send;

  // Shadow only reloads from IDLE or on the done cycle, so din is free mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
    end else begin
      if (w_load) begin
        r_shadow <= din;
      end
      if (w_idle_start) begin
        r_state <= SEND;
      end else if (done && !start) begin
        r_state <= IDLE;
      end
    end
  end

endmodule
